instr_fetch: RTL

Instruction fetch stage for the ARM32 core. It holds the program counter and issues word requests to instruction memory using a request/acknowledge handshake. It captures each returned word in an instruction register and presents it to decode; `Instr[23:0]` is what feeds the immediate extender. It also applies taken-branch redirects using the extender's `ExtImm` output, computing the target as branch PC + 8 + immediate.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/branch_target.sv | 18 +
 rtl/instr_fetch.sv | 118 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FULL = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_OFFSET   = 32'd8;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_target.sv
`default_nettype none
// ============================================================================
// Module      : branch_target
// Description : Branch target adder, pc + 8 + imm modulo 2^32.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  output logic [31:0] target
);

  assign target = pc + PC_OFFSET + imm;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : PC, request/ack instruction fetch and branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRData,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        DecodeReady,
  input  logic        BranchTaken,
  input  logic [31:0] BranchPC,
  input  logic [31:0] BranchImm
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_req_addr, w_req_addr_nxt;
  logic         r_kill, w_kill_nxt;
  logic [31:0]  r_instr, w_instr_nxt;
  logic [31:0]  r_instr_pc, w_instr_pc_nxt;
  logic [31:0]  w_target;

  branch_target u_branch_target (
    .pc     (BranchPC),
    .imm    (BranchImm),
    .target (w_target)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= align_word(RESET_PC);
      r_req_addr <= align_word(RESET_PC);
      r_kill     <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= align_word(w_pc_nxt);
      r_req_addr <= align_word(w_req_addr_nxt);
      r_kill     <= w_kill_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_addr_nxt = r_req_addr;
    w_kill_nxt     = r_kill;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    unique case (r_state)
      IDLE: begin
        w_state_nxt = BUSY;
        if (BranchTaken) begin
          w_pc_nxt       = w_target;
          w_req_addr_nxt = w_target;
        end else begin
          w_req_addr_nxt = r_pc;
        end
      end
      BUSY: begin
        if (!ImemAck) begin
          // The address must stay put mid-request; remember the redirect and drop the reply.
          if (BranchTaken) begin
            w_pc_nxt   = w_target;
            w_kill_nxt = 1'b1;
          end
        end else if (BranchTaken) begin
          w_pc_nxt       = w_target;
          w_req_addr_nxt = w_target;
          w_kill_nxt     = 1'b0;
        end else if (r_kill) begin
          w_kill_nxt     = 1'b0;
          w_req_addr_nxt = r_pc;
        end else begin
          w_instr_nxt    = ImemRData;
          w_instr_pc_nxt = r_req_addr;
          w_pc_nxt       = r_req_addr + INSTR_BYTES;
          w_state_nxt    = FULL;
        end
      end
      FULL: begin
        if (BranchTaken) begin
          w_pc_nxt       = w_target;
          w_req_addr_nxt = w_target;
          w_state_nxt    = BUSY;
        end else if (DecodeReady) begin
          w_req_addr_nxt = r_pc;
          w_state_nxt    = BUSY;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign ImemReq    = (r_state == BUSY);
  assign InstrValid = (r_state == FULL);
  assign ImemAddr   = r_req_addr;
  assign Instr      = r_instr;
  assign InstrPC    = r_instr_pc;

endmodule
`default_nettype wire
